// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM:
// states, opcodes, mux selects, ALU ops and trap causes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MDR    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/riscv_multicycle_ctrl_timer.sv
// Memory wait watchdog: counts stalled request cycles and flags
// expiry on the TIMEOUT_CYCLES-th one (0 disables it).
module ctrl_mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds stalls already seen, so this is the limit cycle
    assign expired = (TIMEOUT_CYCLES != 0) && count_en && (count_q == LIMIT);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with shared memory port and wait trap.
// Define RISCV_CTRL_INSTRET_EN to build the retired-instruction counter.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic [3:0]           state_out,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
);

    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       expired, wait_clear, wait_en;
    logic       unused_zero;

    // zero is consumed by the datapath through pc_write_cond
    assign unused_zero = zero;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                unique case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                    OPC_OP:              state_d = S_EXECR;
                    OPC_OP_IMM:          state_d = S_EXECI;
                    OPC_BRANCH:          state_d = S_BEQ;
                    OPC_JAL:             state_d = S_JAL;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR:
                state_d = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD, S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;
        result_src    = RES_ALUOUT;
        trap          = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MDR;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a     = SRCA_RS1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_TRAP:     trap = 1'b1;
            default: ;
        endcase
    end

    assign state_out  = state_q;
    assign trap_cause = cause_q;

    assign wait_en    = mem_req & ~mem_ready;
    assign wait_clear = (state_d != state_q) &&
                        (state_d inside {S_FETCH, S_MEMREAD, S_MEMWRITE});

    ctrl_mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .count_en(wait_en),
        .expired (expired)
    );

`ifdef RISCV_CTRL_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire;

    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
